// File: rtl/axi_modport_slave_pkg.sv
// ============================================================================
// axi_modport_pkg : burst/response encodings, FSM states, beat-address helper
// Rev 1.0
// ============================================================================
`default_nettype none

package axi_modport_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Sizes above one word are clamped to 4 bytes since the data path is 32 bits.
    function automatic logic [31:0] beat_next_addr(
        input logic [31:0] addr,
        input logic [2:0]  size,
        input logic [3:0]  len,
        input logic [1:0]  burst
    );
        logic [1:0]  sz;
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] incr;
        sz   = (size > 3'd2) ? 2'd2 : size[1:0];
        step = 32'd1 << sz;
        mask = ((32'(len) + 32'd1) << sz) - 32'd1;
        incr = addr + step;
        case (burst)
            BURST_FIXED: beat_next_addr = addr;
            BURST_WRAP:  beat_next_addr = (addr & ~mask) | (incr & mask);
            default:     beat_next_addr = incr;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_modport_slave_if.sv
// ============================================================================
// axi_modport_slave_if : AXI4 bus bundle with master and slave views
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi_modport_slave_if;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER;
    logic        AWVALID, AWREADY;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WUSER, WVALID, WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BUSER, BVALID, BREADY;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER;
    logic        ARVALID, ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [3:0]  RRESP;
    logic        RLAST, RUSER, RVALID, RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
               AWQOS, AWREGION, AWUSER, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WUSER, WVALID,
        output WREADY,
        output BID, BRESP, BUSER, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
               ARQOS, ARREGION, ARUSER, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
               AWQOS, AWREGION, AWUSER, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WUSER, WVALID,
        input  WREADY,
        input  BID, BRESP, BUSER, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
               ARQOS, ARREGION, ARUSER, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
        output RREADY
    );
endinterface

`default_nettype wire

// File: rtl/axi_modport_slave_addr_gen.sv
// ============================================================================
// axi_addr_gen : combinational next-beat address for FIXED/INCR/WRAP bursts
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_addr_gen
    import axi_modport_pkg::*;
(
    input  wire logic [31:0] addr_i,
    input  wire logic [2:0]  size_i,
    input  wire logic [3:0]  len_i,
    input  wire logic [1:0]  burst_i,
    output logic      [31:0] next_o
);
    assign next_o = beat_next_addr(addr_i, size_i, len_i, burst_i);
endmodule

`default_nettype wire

// File: rtl/axi_modport_slave.sv
// ============================================================================
// axi_modport_slave : AXI4 slave with word-addressed RAM, one burst per channel
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_modport_slave
    import axi_modport_pkg::*;
#(
    parameter int         MEM_WORDS = 256,
    parameter logic [1:0] OKAY_RESP = RESP_OKAY,
    parameter logic [1:0] ERR_RESP  = RESP_SLVERR
) (
    input  wire logic          clk,
    input  wire logic          rst,
    axi_modport_slave_if.slave bus
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0] mem_q [MEM_WORDS];

    w_state_e    w_state_q, w_state_d;
    logic [3:0]  awid_q, awlen_q, wbeat_q;
    logic [31:0] awaddr_q;
    logic [2:0]  awsize_q;
    logic [1:0]  awburst_q;
    logic        werr_q;

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  arid_q, arlen_q, rbeat_q;
    logic [31:0] araddr_q, rdata_q;
    logic [2:0]  arsize_q;
    logic [1:0]  arburst_q, rresp_q;

    logic [31:0]      w_waddr_next, w_raddr_next, w_fetch_addr, w_fetch_data;
    logic             w_aw_fire, w_w_fire, w_wlast_beat, w_waddr_ok;
    logic             w_ar_fire, w_r_fire, w_rlast, w_fetch_ok;
    logic [IDX_W-1:0] w_widx, w_fetch_idx;
    logic             w_unused;

    axi_addr_gen u_waddr_gen (.addr_i(awaddr_q), .size_i(awsize_q), .len_i(awlen_q),
                              .burst_i(awburst_q), .next_o(w_waddr_next));
    axi_addr_gen u_raddr_gen (.addr_i(araddr_q), .size_i(arsize_q), .len_i(arlen_q),
                              .burst_i(arburst_q), .next_o(w_raddr_next));

    assign w_unused = ^{bus.AWLOCK, bus.AWCACHE, bus.AWPROT, bus.AWQOS, bus.AWREGION,
                        bus.AWUSER, bus.WID, bus.WUSER, bus.ARLOCK, bus.ARCACHE,
                        bus.ARPROT, bus.ARQOS, bus.ARREGION, bus.ARUSER};

    // ---------------- write channel ----------------
    assign w_aw_fire    = (w_state_q == W_IDLE) && bus.AWVALID;
    assign w_w_fire     = (w_state_q == W_DATA) && bus.WVALID;
    assign w_wlast_beat = (wbeat_q == awlen_q);
    assign w_waddr_ok   = 32'(awaddr_q[31:2]) < 32'(MEM_WORDS);
    assign w_widx       = awaddr_q[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) w_state_q <= W_IDLE;
        else     w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (bus.AWVALID) w_state_d = W_DATA;
            W_DATA:  if (bus.WVALID && w_wlast_beat) w_state_d = W_RESP;
            W_RESP:  if (bus.BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        bus.AWREADY = !rst && (w_state_q == W_IDLE);
        bus.WREADY  = !rst && (w_state_q == W_DATA);
        bus.BVALID  = !rst && (w_state_q == W_RESP);
        bus.BRESP   = bus.BVALID ? (werr_q ? ERR_RESP : OKAY_RESP) : 2'b00;
        bus.BID     = awid_q;
        bus.BUSER   = 1'b0;
    end

    // Length-driven termination; a misplaced WLAST only marks the burst as failed.
    always_ff @(posedge clk) begin
        if (rst) begin
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
        end else if (w_aw_fire) begin
            awid_q    <= bus.AWID;
            awaddr_q  <= bus.AWADDR;
            awlen_q   <= bus.AWLEN;
            awsize_q  <= bus.AWSIZE;
            awburst_q <= bus.AWBURST;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
        end else if (w_w_fire) begin
            awaddr_q <= w_waddr_next;
            wbeat_q  <= wbeat_q + 4'd1;
            if (!w_waddr_ok || (bus.WLAST != w_wlast_beat)) werr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_w_fire && w_waddr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.WSTRB[b]) mem_q[w_widx][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    assign w_ar_fire    = (r_state_q == R_IDLE) && bus.ARVALID;
    assign w_r_fire     = (r_state_q == R_DATA) && bus.RREADY;
    assign w_rlast      = (rbeat_q == arlen_q);
    assign w_fetch_addr = w_ar_fire ? bus.ARADDR : w_raddr_next;
    assign w_fetch_ok   = 32'(w_fetch_addr[31:2]) < 32'(MEM_WORDS);
    assign w_fetch_idx  = w_fetch_addr[IDX_W+1:2];
    assign w_fetch_data = w_fetch_ok ? mem_q[w_fetch_idx] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) r_state_q <= R_IDLE;
        else     r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (bus.ARVALID) r_state_d = R_DATA;
            R_DATA:  if (bus.RREADY && w_rlast) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        bus.ARREADY = !rst && (r_state_q == R_IDLE);
        bus.RVALID  = !rst && (r_state_q == R_DATA);
        bus.RLAST   = bus.RVALID && w_rlast;
        bus.RID     = arid_q;
        bus.RDATA   = rdata_q;
        bus.RRESP   = {2'b00, rresp_q};
        bus.RUSER   = 1'b0;
    end

    // The next beat is prefetched into rdata_q on each accept, so beats flow with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rbeat_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else if (w_ar_fire) begin
            arid_q    <= bus.ARID;
            araddr_q  <= bus.ARADDR;
            arlen_q   <= bus.ARLEN;
            arsize_q  <= bus.ARSIZE;
            arburst_q <= bus.ARBURST;
            rbeat_q   <= '0;
            rdata_q   <= w_fetch_data;
            rresp_q   <= w_fetch_ok ? OKAY_RESP : ERR_RESP;
        end else if (w_r_fire && !w_rlast) begin
            araddr_q <= w_raddr_next;
            rbeat_q  <= rbeat_q + 4'd1;
            rdata_q  <= w_fetch_data;
            rresp_q  <= w_fetch_ok ? OKAY_RESP : ERR_RESP;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_axi_modport_slave.sv
// ============================================================================
// tb_axi_modport_slave : directed and random bursts against a memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_modport_slave;
    import axi_modport_pkg::*;

    localparam int MEM_WORDS = 256;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];

    axi_modport_slave_if bus();

    axi_modport_slave #(.MEM_WORDS(MEM_WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat address from the burst rules, written with division rather than masks.
    function automatic logic [31:0] m_next(input logic [31:0] a, input logic [2:0] size,
                                           input logic [3:0] len, input logic [1:0] burst);
        logic [31:0] step, total, base;
        step  = (size > 3'd2) ? 32'd4 : (32'd1 << size);
        total = (32'(len) + 32'd1) * step;
        base  = (a / total) * total;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) return (a + step >= base + total) ? base : a + step;
        return a + step;
    endfunction

    task automatic set_wl(input logic [3:0] len);
        for (int i = 0; i < 16; i++) wl[i] = (i == int'(len));
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic [1:0]  exp_resp;
        int          n;
        exp_resp = 2'b00;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            if (a >= 32'(MEM_WORDS * 4)) exp_resp = 2'b10;
            else for (int b = 0; b < 4; b++)
                if (ws[i][b]) model_mem[int'(a >> 2)][b*8 +: 8] = wd[i][b*8 +: 8];
            if (wl[i] != (i == int'(len))) exp_resp = 2'b10;
            a = m_next(a, size, len, burst);
        end
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
        bus.AWBURST = burst; bus.AWVALID = 1'b1;
        n = 0;
        while (bus.AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("aw_ready", 64'(bus.AWREADY), 64'd1);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.WDATA = wd[i]; bus.WSTRB = ws[i]; bus.WLAST = wl[i]; bus.WVALID = 1'b1;
            n = 0;
            while (bus.WREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            check("w_ready", 64'(bus.WREADY), 64'd1);
            @(negedge clk);
            bus.WVALID = 1'b0; bus.WLAST = 1'b0;
            if ($urandom_range(3) == 0) @(negedge clk);
        end
        n = 0;
        while (bus.BVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        repeat ($urandom_range(2)) @(negedge clk);
        check("b_valid", 64'(bus.BVALID), 64'd1);
        check("b_id", 64'(bus.BID), 64'(id));
        check("b_resp", 64'(bus.BRESP), 64'(exp_resp));
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("b_done", 64'(bus.BVALID), 64'd0);
    endtask

    // stall_beat < 0 gives random backpressure; otherwise that beat is held 5 cycles.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
        logic [31:0] a, exp_data;
        logic [3:0]  exp_resp;
        logic [40:0] snap;
        int          n, stall;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size;
        bus.ARBURST = burst; bus.ARVALID = 1'b1;
        n = 0;
        while (bus.ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("ar_ready", 64'(bus.ARREADY), 64'd1);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            check("r_valid", 64'(bus.RVALID), 64'd1);
            stall = (stall_beat < 0) ? int'($urandom_range(2)) : ((i == stall_beat) ? 5 : 0);
            snap = {bus.RDATA, bus.RLAST, bus.RRESP, bus.RID};
            repeat (stall) begin
                @(negedge clk);
                check("r_hold", 64'({bus.RDATA, bus.RLAST, bus.RRESP, bus.RID}), 64'(snap));
            end
            if (a >= 32'(MEM_WORDS * 4)) begin exp_data = 32'd0; exp_resp = 4'b0010; end
            else begin exp_data = model_mem[int'(a >> 2)]; exp_resp = 4'b0000; end
            check("r_data", 64'(bus.RDATA), 64'(exp_data));
            check("r_resp", 64'(bus.RRESP), 64'(exp_resp));
            check("r_last", 64'(bus.RLAST), 64'(i == int'(len)));
            check("r_id", 64'(bus.RID), 64'(id));
            bus.RREADY = 1'b1;
            @(negedge clk);
            bus.RREADY = 1'b0;
            a = m_next(a, size, len, burst);
        end
        check("r_done", 64'(bus.RVALID), 64'd0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          n;

        rst = 1'b1;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWLOCK = 0; bus.AWCACHE = 0; bus.AWPROT = 0; bus.AWQOS = 0; bus.AWREGION = 0;
        bus.AWUSER = 0; bus.AWVALID = 0;
        bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 0; bus.WUSER = 0; bus.WVALID = 0;
        bus.BREADY = 0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
        bus.ARLOCK = 0; bus.ARCACHE = 0; bus.ARPROT = 0; bus.ARQOS = 0; bus.ARREGION = 0;
        bus.ARUSER = 0; bus.ARVALID = 0; bus.RREADY = 0;

        // Reset: everything low, then both address channels ready.
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bus.AWREADY, bus.WREADY, bus.BVALID, bus.BID, bus.BRESP,
              bus.BUSER, bus.ARREADY, bus.RVALID, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST,
              bus.RUSER}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_awready", 64'(bus.AWREADY), 64'd1);
        check("reset_release_arready", 64'(bus.ARREADY), 64'd1);

        // Fill the whole RAM so every later read has a known value.
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            set_wl(4'd15);
            do_write(4'(b), 32'(b * 64), 4'd15, 3'd2, BURST_INCR);
        end

        // INCR write / read back.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        set_wl(4'd3);
        do_write(4'd5, 32'h10, 4'd3, 3'd2, BURST_INCR);
        do_read(4'd7, 32'h10, 4'd3, 3'd2, BURST_INCR, -1);

        // WRAP read over words 0..3.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        set_wl(4'd3);
        do_write(4'd1, 32'h0, 4'd3, 3'd2, BURST_INCR);
        do_read(4'd2, 32'h8, 4'd3, 3'd2, BURST_WRAP, -1);

        // Byte strobes.
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF; set_wl(4'd0);
        do_write(4'd3, 32'h20, 4'd0, 3'd2, BURST_INCR);
        wd[0] = 32'h0; ws[0] = 4'b0101;
        do_write(4'd3, 32'h20, 4'd0, 3'd2, BURST_INCR);
        do_read(4'd3, 32'h20, 4'd0, 3'd2, BURST_INCR, -1);

        // Long backpressure in the middle of a burst.
        do_read(4'd9, 32'h40, 4'd7, 3'd2, BURST_INCR, 3);

        // Out-of-range write and read, plus a burst straddling the end of RAM.
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF; set_wl(4'd0);
        do_write(4'd4, 32'h400, 4'd0, 3'd2, BURST_INCR);
        do_read(4'd4, 32'h400, 4'd0, 3'd2, BURST_INCR, -1);
        do_read(4'd4, 32'h0, 4'd0, 3'd2, BURST_INCR, -1);
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        set_wl(4'd3);
        do_write(4'd6, 32'h3F8, 4'd3, 3'd2, BURST_INCR);
        do_read(4'd6, 32'h3F8, 4'd3, 3'd2, BURST_INCR, -1);

        // Early WLAST on a two-beat burst.
        wd[0] = 32'h1111_2222; wd[1] = 32'h3333_4444; ws[0] = 4'hF; ws[1] = 4'hF;
        wl[0] = 1'b1; wl[1] = 1'b0;
        do_write(4'd8, 32'h80, 4'd1, 3'd2, BURST_INCR);
        do_read(4'd8, 32'h80, 4'd1, 3'd2, BURST_INCR, -1);

        // Reset while beat 1 of a 4-beat read is on the bus.
        bus.ARID = 4'd3; bus.ARADDR = 32'h10; bus.ARLEN = 4'd3; bus.ARSIZE = 3'd2;
        bus.ARBURST = BURST_INCR; bus.ARVALID = 1'b1;
        n = 0;
        while (bus.ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        check("mid_rst_beat1_data", 64'(bus.RDATA), 64'(model_mem[5]));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rvalid", 64'(bus.RVALID), 64'd0);
        check("mid_rst_arready", 64'(bus.ARREADY), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release_arready", 64'(bus.ARREADY), 64'd1);
        check("mid_rst_release_rvalid", 64'(bus.RVALID), 64'd0);
        do_read(4'd3, 32'h10, 4'd3, 3'd2, BURST_INCR, -1);

        // Random bursts, each write followed by a read of a random region.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 2; k++) begin
                size  = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd2;
                burst = 2'($urandom_range(3));
                len   = 4'($urandom_range(15));
                if (burst == BURST_WRAP) begin
                    case ($urandom_range(3))
                        0: len = 4'd1;
                        1: len = 4'd3;
                        2: len = 4'd7;
                        default: len = 4'd15;
                    endcase
                end
                addr = 32'($urandom_range(MEM_WORDS + 12)) * 32'd4 + 32'($urandom_range(3));
                addr = addr & ~(((size > 3'd2) ? 32'd4 : (32'd1 << size)) - 32'd1);
                if (k == 0) begin
                    for (int i = 0; i < 16; i++) begin
                        wd[i] = $urandom; ws[i] = 4'($urandom_range(15));
                    end
                    set_wl(len);
                    if ($urandom_range(7) == 0) wl[$urandom_range(int'(len))] = ~wl[0] | (len == 4'd0);
                    do_write(4'($urandom_range(15)), addr, len, size, burst);
                end else begin
                    do_read(4'($urandom_range(15)), addr, len, size, burst, -1);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
